// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the memory responder and its word array.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_e;

    localparam logic [31:0] MEM_ERR_DATA = 32'hdeadbeef;

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Request/response bundle between the core's memory port and the responder.
interface riscv_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (output req, we, addr, be, wdata,
                    input  ready, rdata, err, busy);

    modport slave  (input  req, we, addr, be, wdata,
                    output ready, rdata, err, busy);
endinterface

// File: rtl/riscv_mem_array.sv
// Word array with byte-enable synchronous write and asynchronous read.
module riscv_mem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] word_addr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // Not reset: contents survive a responder reset.
    logic [31:0] _mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) _mem[word_addr] <= be_merge(_mem[word_addr], wdata, wbe);
    end

    assign rdata = _mem[word_addr];

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder: accepts one request, waits WAIT_CYCLES, answers with a ready pulse.
//
// state | meaning
// IDLE  | no transaction; accept on req
// WAIT  | request latched, counting down wait states
// RESP  | ready pulse cycle carrying rdata/err
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_mem_responder_if.slave  bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

    mem_resp_state_e state;
    logic [3:0]      cnt;
    logic            lat_we;
    logic [31:0]     lat_addr;
    logic [3:0]      lat_be;
    logic [31:0]     lat_wdata;
    logic            ready_q;
    logic            err_q;
    logic            busy_q;
    logic [31:0]     rdata_q;

    logic            go_resp;
    logic            cur_we;
    logic [31:0]     cur_addr;
    logic [3:0]      cur_be;
    logic [31:0]     cur_wdata;
    logic            cur_err;
    logic            wr_en;
    logic [31:0]     mem_rdata;
    logic [31:0]     resp_data;

    // With zero wait states the RESP-entry edge is the acceptance edge, so the
    // live bus fields are used there; otherwise the latched copies.
    always_comb begin
        go_resp   = ((state == IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == 4'd0));
        cur_we    = (state == IDLE) ? bus.we    : lat_we;
        cur_addr  = (state == IDLE) ? bus.addr  : lat_addr;
        cur_be    = (state == IDLE) ? bus.be    : lat_be;
        cur_wdata = (state == IDLE) ? bus.wdata : lat_wdata;
        cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr >= MEM_BYTES) ||
                    (cur_we && (cur_be == 4'b0000));
        wr_en     = go_resp && cur_we && !cur_err && rst;
        if (cur_err)     resp_data = MEM_ERR_DATA;
        else if (cur_we) resp_data = 32'd0;
        else             resp_data = mem_rdata;
    end

    riscv_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk       (clk),
        .wr_en     (wr_en),
        .word_addr (cur_addr[AW+1:2]),
        .wbe       (cur_be),
        .wdata     (cur_wdata),
        .rdata     (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_be    <= 4'd0;
            lat_wdata <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        lat_we    <= bus.we;
                        lat_addr  <= bus.addr;
                        lat_be    <= bus.be;
                        lat_wdata <= bus.wdata;
                        busy_q    <= 1'b1;
                        cnt       <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    rdata_q <= 32'd0;
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                state   <= RESP;
                ready_q <= 1'b1;
                err_q   <= cur_err;
                rdata_q <= resp_data;
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder against a word-array reference model.
module tb_riscv_mem_responder;
    timeunit 1ns;
    timeprecision 1ps;
    import riscv_mem_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] DEAD  = 32'hdeadbeef;

    logic clk = 1'b0;
    logic rst = 1'b0;

    riscv_mem_responder_if m ();
    riscv_mem_responder_if m0 ();

    riscv_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk (clk), .rst (rst), .bus (m)
    );

    riscv_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk (clk), .rst (rst), .bus (m0)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic w, input logic [31:0] a, input logic [3:0] b);
        return (a % 4 != 0) || (a >= 4 * DEPTH) || (w && b == 4'b0000);
    endfunction

    // Drives one request on the WAIT_CYCLES=2 instance, scrambling the bus after acceptance.
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic e);
        @(negedge clk);
        m.req = 1'b1; m.we = w; m.addr = a; m.be = b; m.wdata = d;
        lat = -1; rd = 'x; e = 'x;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                chk("busy_after_accept", 32'(m.busy), 32'd1);
                m.we = 1'($urandom); m.addr = $urandom; m.be = 4'($urandom);
                m.wdata = $urandom; m.req = 1'($urandom);
            end
            if (m.ready) begin
                lat = i; rd = m.rdata; e = m.err;
                break;
            end
        end
        m.req = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_resp", 32'(m.ready), 32'd0);
        chk("busy_after_resp", 32'(m.busy), 32'd0);
    endtask

    task automatic txn_check(input string tag, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d);
        int          lat;
        logic [31:0] rd;
        logic        e;
        logic        e_exp;
        logic [31:0] r_exp;
        int          idx;
        txn(w, a, b, d, lat, rd, e);
        e_exp = model_err(w, a, b);
        idx   = int'(a / 4) % DEPTH;
        if (e_exp)  r_exp = DEAD;
        else if (w) r_exp = 32'd0;
        else        r_exp = model[idx];
        if (w && !e_exp) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_rdata"}, rd, r_exp);
        chk({tag, "_err"}, 32'(e), 32'(e_exp));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] va;
        logic [31:0] vb;
        int          kind;

        m.req = 0; m.we = 0; m.addr = 0; m.be = 0; m.wdata = 0;
        m0.req = 0; m0.we = 0; m0.addr = 0; m0.be = 0; m0.wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(m.ready), 32'd0);
        chk("reset_busy", 32'(m.busy), 32'd0);
        chk("reset_err", 32'(m.err), 32'd0);
        chk("reset_rdata", m.rdata, 32'd0);
        chk("reset_ready0", 32'(m0.ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) txn_check("init", 1'b1, 32'(i * 4), 4'hf, $urandom);

        txn_check("preload3", 1'b1, 32'd12, 4'hf, 32'h004180e7);
        txn_check("read_latency", 1'b0, 32'd12, 4'h0, 32'd0);

        txn_check("preload1", 1'b1, 32'd4, 4'hf, 32'h11223344);
        txn_check("be_write", 1'b1, 32'd4, 4'b0101, 32'haabbccdd);
        chk("be_mem1", dut.u_array._mem[1], 32'h11bb33dd);
        txn_check("be_readback", 1'b0, 32'd4, 4'h0, 32'd0);

        txn_check("err_misaligned", 1'b0, 32'd6, 4'hf, 32'd0);
        txn_check("err_range", 1'b1, 32'(4 * DEPTH), 4'hf, 32'h0bad0bad);
        chk("err_range_mem0", dut.u_array._mem[0], model[0]);
        txn_check("err_be0", 1'b1, 32'd8, 4'h0, 32'h12345678);
        chk("err_be0_mem2", dut.u_array._mem[2], model[2]);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
            else if (kind == 1) a = $urandom_range(4 * DEPTH, 32'hffff_fff0) & 32'hffff_fffc;
            else                a = $urandom_range(0, DEPTH - 1) * 4;
            txn_check("random", 1'($urandom), a, 4'($urandom), $urandom);
        end

        // Reset in WAIT aborts the write and clears outputs without a clock edge.
        @(negedge clk);
        m.req = 1'b1; m.we = 1'b1; m.addr = 32'd8; m.be = 4'hf; m.wdata = ~model[2];
        @(posedge clk); #1;
        chk("rst_mid_busy_before", 32'(m.busy), 32'd1);
        m.req = 1'b0;
        #1;
        rst = 1'b0;
        #0.001;
        chk("rst_mid_ready", 32'(m.ready), 32'd0);
        chk("rst_mid_busy", 32'(m.busy), 32'd0);
        chk("rst_mid_err", 32'(m.err), 32'd0);
        #0.001;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_mem2", dut.u_array._mem[2], model[2]);
        chk("rst_mid_no_ready", 32'(m.ready), 32'd0);
        txn_check("after_reset_read", 1'b0, 32'd8, 4'h0, 32'd0);

        // Zero wait states, req held high: ready on edges 1 and 3.
        va = $urandom; vb = $urandom;
        @(negedge clk);
        m0.req = 1'b1; m0.we = 1'b1; m0.addr = 32'd20; m0.be = 4'hf; m0.wdata = va;
        @(posedge clk); #1;
        chk("zw_wr_edge1", 32'(m0.ready), 32'd1);
        m0.addr = 32'd36; m0.wdata = vb;
        @(posedge clk); #1;
        chk("zw_wr_edge2", 32'(m0.ready), 32'd0);
        @(posedge clk); #1;
        chk("zw_wr_edge3", 32'(m0.ready), 32'd1);
        m0.req = 1'b0;
        @(posedge clk); #1;
        chk("zw_mem5", dut0.u_array._mem[5], va);
        chk("zw_mem9", dut0.u_array._mem[9], vb);
        @(negedge clk);
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 32'd20;
        @(posedge clk); #1;
        chk("zw_rd_edge1", 32'(m0.ready), 32'd1);
        chk("zw_rd1_data", m0.rdata, va);
        m0.addr = 32'd36;
        @(posedge clk); #1;
        chk("zw_rd_edge2", 32'(m0.ready), 32'd0);
        @(posedge clk); #1;
        chk("zw_rd_edge3", 32'(m0.ready), 32'd1);
        chk("zw_rd2_data", m0.rdata, vb);
        chk("zw_rd2_err", 32'(m0.err), 32'd0);
        m0.req = 1'b0;
        @(posedge clk); #1;
        chk("zw_busy_end", 32'(m0.busy), 32'd0);

        for (int i = 0; i < DEPTH; i++) chk("final_mem", dut.u_array._mem[i], model[i]);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Bus responder (memory side) for the multicycle RISC-V core's instruction/data memory port.
- Accepts one word or sub-word read/write request at a time.
- Inserts a programmable number of wait states, then completes the request with a one-cycle `ready` pulse.
- Lets benches run the core against realistic memory latency instead of zero-latency combinational memory.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words stored; must be a power of 2.
- WAIT_CYCLES, 2: wait cycles between request acceptance and `ready`; legal range 0..15.

Ports:
- clk, in, 1: single clock, rising-edge.
- rst, in, 1: asynchronous, active-low reset.
- req, in, 1: request valid; held high by the initiator until `ready`.
- we, in, 1: 1 = write, 0 = read; sampled at acceptance.
- addr, in, 32: byte address; sampled at acceptance.
- be, in, 4: byte enables for writes (bit i = byte i); ignored for reads.
- wdata, in, 32: write data; sampled at acceptance.
- ready, out, 1: one-cycle completion pulse.
- rdata, out, 32: read data, valid only while `ready` is high after a read.
- err, out, 1: completion carries an error; valid only with `ready`.
- busy, out, 1: high from acceptance through the `ready` cycle.

Behaviour:
- **Reset** (`rst`=0, asynchronous):
  - state = IDLE.
  - ready = 0, err = 0, busy = 0, rdata = 0.
  - Wait counter = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-transaction aborts it: no write commits unless the write edge already occurred, and no `ready` is produced.
- **FSM states**, in a shared enum: IDLE, WAIT, RESP.
- **IDLE**:
  - On a rising edge with `req`=1, latch we/addr/be/wdata into internal registers and set busy = 1.
  - Go to WAIT if WAIT_CYCLES > 0, else go directly to RESP.
  - Load the counter with WAIT_CYCLES - 1.
- **WAIT**:
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP.
  - Total acceptance-to-`ready` latency is WAIT_CYCLES + 1 edges.
- **RESP**, registered outputs during this one cycle:
  - ready = 1.
  - On a read: rdata = word at latched addr[log2(DEPTH_WORDS)+1:2].
  - On a write: bytes with be[i] = 1 are written at the RESP-entry edge; the others are unchanged; rdata = 0.
  - err = 1 in any of these cases, and the memory is then not written:
    - latched addr[1:0] != 0;
    - addr >= 4*DEPTH_WORDS;
    - a write with be = 0.
  - On err, rdata = 32'hdeadbeef.
  - Next edge: go to IDLE with ready = 0 and busy = 0.
- **Back-to-back requests**:
  - `req` still high in the cycle after `ready` is a NEW request.
  - It is accepted from IDLE at the next edge.
  - Minimum turnaround is one idle cycle between `ready` pulses.
- **Protocol rules**:
  - Changes to we/addr/be/wdata after acceptance are ignored, because latched values are used.
  - `req` dropping before `ready` does not cancel the transaction; it completes normally.
- **Address width rule**: the out-of-range check uses the full 32-bit address; there is no wrap-around aliasing.
- **Backdoor array**: the internal array is named `_mem`, so benches can preload and check it hierarchically, like the register-file `_reg`.

Decomposition:
- Shared package `riscv_mem_pkg`:
  - state enum mem_resp_state_e (IDLE/WAIT/RESP);
  - localparam MEM_ERR_DATA = 32'hdeadbeef;
  - a helper function for the byte-enable merge of old word, new word and `be`.
- Sub-module `riscv_mem_array`:
  - synchronous-write, asynchronous-read word array with byte enables, holding `_mem`;
  - the responder instantiates one and drives its write strobe only in the RESP-entry cycle when there is no error.

Test Plan:
- Read latency:
  - Stimulus: preload _mem[3] = 32'h004180e7, WAIT_CYCLES = 2; pulse `req` with addr = 12, we = 0.
  - Response: `ready` high exactly 3 edges after acceptance; rdata = 32'h004180e7; err = 0; busy low the cycle after.
- Byte-enable write:
  - Stimulus: _mem[1] = 32'h11223344; write addr = 4, be = 4'b0101, wdata = 32'haabbccdd.
  - Response: _mem[1] = 32'h11bb33dd; err = 0; following read returns 32'h11bb33dd.
- Errors:
  - Misaligned read, addr = 6 -> err = 1, rdata = 32'hdeadbeef.
  - Write addr = 4*DEPTH_WORDS, be = 4'hf -> err = 1, memory unchanged.
  - Write with be = 0 -> err = 1.
- Zero wait states:
  - Stimulus: WAIT_CYCLES = 0, two reads held back-to-back with `req` high continuously.
  - Response: `ready` pulses on edges 1 and 3; the second rdata corresponds to the address present at the second acceptance.
- Reset mid-operation:
  - Stimulus: accept a write to addr 8, then drop `rst` to 0 for 2 ps during WAIT.
  - Response: ready/busy/err go to 0 immediately, without waiting for a clock edge; _mem[2] is unchanged; a subsequent normal read completes correctly.
- Core integration:
  - Stimulus: connect to riscv_legacy; run the jalr program (jalr ra,x3,4 at word 0; jalr ra,x4,-4 at word 3).
  - Response: PC sequence 0 -> 12 -> 0 and ra = 4 then 16, once the cycle counts are extended for wait states.
